// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
// Exception cause codes and stage state names.
package cpu_pkg;

  localparam int EXC_CAUSE_W = 5;

  typedef logic [EXC_CAUSE_W-1:0] exc_cause_t;

  localparam exc_cause_t EXC_CAUSE_NONE = 5'd0;
  localparam exc_cause_t EXC_CAUSE_ADEL = 5'd4;
  localparam exc_cause_t EXC_CAUSE_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } stage_st_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages.
// master drives the upstream side, slave is the stage.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int EXC_W  = 5
);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic [EXC_W-1:0]  i_exc_cause;
  logic              i_bad_addr;
  logic              i_dmem_we;
  logic              i_is_branch;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [EXC_W-1:0]  o_exc_cause;
  logic              o_is_branch;
  logic              o_in_delay_slot;

  modport master (
    output i_valid, i_data, i_ctrl, i_exc_cause,
    output i_bad_addr, i_dmem_we, i_is_branch,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_ctrl,
    input  o_exc_cause, o_is_branch, o_in_delay_slot
  );

  modport slave (
    input  i_valid, i_data, i_ctrl, i_exc_cause,
    input  i_bad_addr, i_dmem_we, i_is_branch,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_data, o_ctrl,
    output o_exc_cause, o_is_branch, o_in_delay_slot
  );

endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage.
// kill drops the entry and its control bits.
module pipe_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clr,
  input  logic              kill,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [EXC_W-1:0]  d_cause,
  input  logic              d_br,
  input  logic              d_ds,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [EXC_W-1:0]  q_cause,
  output logic              q_br,
  output logic              q_ds
);

  // kill beats load beats clear; payload survives kill
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= '0;
      q_cause <= EXC_W'(EXC_CAUSE_NONE);
      q_br    <= 1'b0;
      q_ds    <= 1'b0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
      q_cause <= d_cause;
      q_br    <= d_br;
      q_ds    <= d_ds;
    end else if (clr) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer.
// Registered ready, flush, delay-slot and cause fold.
module pipe_stage_skid
  import cpu_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int EXC_W  = 5
) (
  input logic clk,
  input logic resetn,
  pipe_stage_skid_if.slave bus
);

  stage_st_t st;

  logic ready_q;
  logic trk_q;
  logic accept;
  logic rel;
  logic flush;

  logic m_load, m_clr, m_from_skid;
  logic s_load, s_clr;
  logic skid_nv;

  logic [EXC_W-1:0] cap_cause;

  logic              m_v, s_v;
  logic [DATA_W-1:0] m_data, s_data, m_d_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
  logic [EXC_W-1:0]  m_cause, s_cause, m_d_cause;
  logic              m_br, s_br, m_d_br;
  logic              m_ds, s_ds, m_d_ds;

  assign flush  = bus.i_flush;
  assign accept = bus.i_valid & ready_q & ~flush;
  assign rel    = m_v & bus.i_ready;

  // bad address overrides any upstream cause
  always_comb begin
    cap_cause = bus.i_exc_cause;
    if (bus.i_bad_addr)
      cap_cause = bus.i_dmem_we ? EXC_W'(EXC_CAUSE_ADES)
                                : EXC_W'(EXC_CAUSE_ADEL);
  end

  // state from slot valid bits; skid implies main
  always_comb begin
    st = ST_EMPTY;
    unique case (1'b1)
      m_v & s_v:  st = ST_SKID;
      m_v & ~s_v: st = ST_FULL;
      ~m_v:       st = ST_EMPTY;
    endcase
  end

  // slot load/clear decisions per state
  always_comb begin
    m_load      = 1'b0;
    m_clr       = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_clr       = 1'b0;
    unique case (st)
      ST_EMPTY: m_load = accept;
      ST_FULL: begin
        m_load = accept & rel;
        s_load = accept & ~rel;
        m_clr  = rel & ~accept;
      end
      ST_SKID: begin
        m_load      = rel;
        m_from_skid = rel;
        s_clr       = rel;
      end
      default: ;
    endcase
  end

  assign m_d_data  = m_from_skid ? s_data  : bus.i_data;
  assign m_d_ctrl  = m_from_skid ? s_ctrl  : bus.i_ctrl;
  assign m_d_cause = m_from_skid ? s_cause : cap_cause;
  assign m_d_br    = m_from_skid ? s_br    : bus.i_is_branch;
  assign m_d_ds    = m_from_skid ? s_ds    : trk_q;

  assign skid_nv = ~flush & (s_load | (s_v & ~s_clr));

  // ready and delay-slot tracker registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b1;
      trk_q   <= 1'b0;
    end else begin
      ready_q <= ~skid_nv;
      if (flush)
        trk_q <= 1'b0;
      else if (accept)
        trk_q <= bus.i_is_branch;
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .EXC_W(EXC_W)
  ) u_main (
    .clk(clk), .resetn(resetn),
    .load(m_load), .clr(m_clr), .kill(flush),
    .d_data(m_d_data), .d_ctrl(m_d_ctrl),
    .d_cause(m_d_cause), .d_br(m_d_br), .d_ds(m_d_ds),
    .q_valid(m_v), .q_data(m_data), .q_ctrl(m_ctrl),
    .q_cause(m_cause), .q_br(m_br), .q_ds(m_ds)
  );

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .EXC_W(EXC_W)
  ) u_skid (
    .clk(clk), .resetn(resetn),
    .load(s_load), .clr(s_clr), .kill(flush),
    .d_data(bus.i_data), .d_ctrl(bus.i_ctrl),
    .d_cause(cap_cause), .d_br(bus.i_is_branch),
    .d_ds(trk_q),
    .q_valid(s_v), .q_data(s_data), .q_ctrl(s_ctrl),
    .q_cause(s_cause), .q_br(s_br), .q_ds(s_ds)
  );

  assign bus.o_ready         = ready_q;
  assign bus.o_valid         = m_v;
  assign bus.o_data          = m_data;
  assign bus.o_ctrl          = m_v ? m_ctrl : '0;
  assign bus.o_exc_cause     = m_cause;
  assign bus.o_is_branch     = m_v & m_br;
  assign bus.o_in_delay_slot = m_ds;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue model plus
// directed literal checks and random traffic.
module tb_pipe_stage_skid;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  pipe_stage_skid_if bus ();

  pipe_stage_skid dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] d;
    logic [15:0] c;
    logic [4:0]  e;
    logic        br;
    logic        ds;
  } ent_t;

  ent_t q[$];
  bit   m_ready = 1'b1;
  bit   m_trk   = 1'b0;

  int checks = 0;
  int passed = 0;

  task automatic chkw(string nm, logic [127:0] act,
                      logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h @%0t",
                  nm, act, exp, $time);
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, want %b @%0t",
                  nm, act, exp, $time);
  endtask

  // reference model: entries in order, at most two held
  initial forever begin
    ent_t e;
    bit   acc;
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      q.delete();
      m_ready = 1'b1;
      m_trk   = 1'b0;
    end else begin
      acc = bus.i_valid && m_ready && !bus.i_flush;
      if (q.size() > 0 && bus.i_ready)
        void'(q.pop_front());
      if (bus.i_flush) begin
        q.delete();
        m_trk = 1'b0;
      end else if (acc) begin
        e.d  = bus.i_data;
        e.c  = bus.i_ctrl;
        if (bus.i_bad_addr)
          e.e = bus.i_dmem_we ? 5'd5 : 5'd4;
        else
          e.e = bus.i_exc_cause;
        e.br = bus.i_is_branch;
        e.ds = m_trk;
        q.push_back(e);
        m_trk = bus.i_is_branch;
      end
      m_ready = q.size() < 2;
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk1("valid", bus.o_valid, q.size() != 0);
    chk1("ready", bus.o_ready, m_ready);
    if (q.size() != 0) begin
      chkw("data", 128'(bus.o_data), 128'(q[0].d));
      chkw("ctrl", 128'(bus.o_ctrl), 128'(q[0].c));
      chkw("cause", 128'(bus.o_exc_cause), 128'(q[0].e));
      chk1("is_branch", bus.o_is_branch, q[0].br);
      chk1("in_ds", bus.o_in_delay_slot, q[0].ds);
    end else begin
      chkw("ctrl_idle", 128'(bus.o_ctrl), 128'(0));
      chk1("br_idle", bus.o_is_branch, 1'b0);
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic drv(bit v, logic [95:0] d, logic [15:0] c,
                     bit br, bit rdy, bit fl, bit bad,
                     bit we, logic [4:0] ex);
    bus.i_valid     = v;
    bus.i_data      = d;
    bus.i_ctrl      = c;
    bus.i_is_branch = br;
    bus.i_ready     = rdy;
    bus.i_flush     = fl;
    bus.i_bad_addr  = bad;
    bus.i_dmem_we   = we;
    bus.i_exc_cause = ex;
  endtask

  task automatic idle(bit rdy);
    drv(0, '0, '0, 0, rdy, 0, 0, 0, 5'd0);
  endtask

  task automatic reset_vals(string p);
    chk1({p, "_valid"}, bus.o_valid, 1'b0);
    chk1({p, "_ready"}, bus.o_ready, 1'b1);
    chkw({p, "_data"}, 128'(bus.o_data), 128'(0));
    chkw({p, "_ctrl"}, 128'(bus.o_ctrl), 128'(0));
    chkw({p, "_cause"}, 128'(bus.o_exc_cause),
         128'(EXC_CAUSE_NONE));
    chk1({p, "_br"}, bus.o_is_branch, 1'b0);
    chk1({p, "_ds"}, bus.o_in_delay_slot, 1'b0);
  endtask

  initial begin
    resetn = 1'b1;
    idle(1);
    #1 resetn = 1'b0;
    repeat (2) nx();
    #1 reset_vals("rst");
    nx();
    resetn = 1'b1;

    // back-to-back stream
    for (int k = 0; k < 4; k++) begin
      drv(1, 96'h100 + k, 16'(k + 1), 0, 1, 0, 0, 0, 5'd0);
      nx();
      chk1("stream_v", bus.o_valid, 1'b1);
      chkw("stream_d", 128'(bus.o_data), 128'(96'h100 + k));
      chk1("stream_rdy", bus.o_ready, 1'b1);
    end
    idle(1);
    nx();
    chk1("stream_end", bus.o_valid, 1'b0);

    // downstream stall, three cycles
    drv(1, 96'hA, 16'h11, 0, 0, 0, 0, 0, 5'd0);
    nx();
    chk1("bp_rdy1", bus.o_ready, 1'b1);
    drv(1, 96'hB, 16'h22, 0, 0, 0, 0, 0, 5'd0);
    nx();
    chk1("bp_rdy0", bus.o_ready, 1'b0);
    drv(1, 96'hC, 16'h33, 0, 0, 0, 0, 0, 5'd0);
    nx();
    chkw("bp_hold", 128'(bus.o_data), 128'(96'hA));
    drv(1, 96'hC, 16'h33, 0, 1, 0, 0, 0, 5'd0);
    nx();
    chkw("bp_B", 128'(bus.o_data), 128'(96'hB));
    nx();
    chkw("bp_C", 128'(bus.o_data), 128'(96'hC));
    idle(1);
    nx();
    chk1("bp_end", bus.o_valid, 1'b0);

    // flush while skid full with a valid input
    drv(1, 96'hD, 16'h44, 0, 0, 0, 0, 0, 5'd0);
    nx();
    drv(1, 96'hE, 16'h55, 0, 0, 0, 0, 0, 5'd0);
    nx();
    drv(1, 96'hF, 16'h66, 0, 0, 1, 0, 0, 5'd0);
    nx();
    chk1("fl_valid", bus.o_valid, 1'b0);
    chkw("fl_ctrl", 128'(bus.o_ctrl), 128'(0));
    chk1("fl_ready", bus.o_ready, 1'b1);
    idle(1);
    nx();
    chk1("fl_nocap", bus.o_valid, 1'b0);

    // cause folding
    drv(1, 96'h1, 16'h1, 0, 1, 0, 1, 1, 5'd10);
    nx();
    chkw("ades", 128'(bus.o_exc_cause), 128'(5));
    drv(1, 96'h2, 16'h1, 0, 1, 0, 1, 0, 5'd10);
    nx();
    chkw("adel", 128'(bus.o_exc_cause), 128'(4));
    drv(1, 96'h3, 16'h1, 0, 1, 0, 0, 1, 5'd10);
    nx();
    chkw("pass", 128'(bus.o_exc_cause), 128'(10));

    // delay slot
    drv(1, 96'h10, 16'h1, 1, 1, 0, 0, 0, 5'd0);
    nx();
    chk1("ds_br", bus.o_is_branch, 1'b1);
    chk1("ds_br_ds", bus.o_in_delay_slot, 1'b0);
    drv(1, 96'h11, 16'h1, 0, 1, 0, 0, 0, 5'd0);
    nx();
    chk1("ds_x", bus.o_in_delay_slot, 1'b1);
    drv(1, 96'h12, 16'h1, 0, 1, 0, 0, 0, 5'd0);
    nx();
    chk1("ds_y", bus.o_in_delay_slot, 1'b0);
    drv(1, 96'h13, 16'h1, 1, 1, 0, 0, 0, 5'd0);
    nx();
    drv(0, '0, '0, 0, 1, 1, 0, 0, 5'd0);
    nx();
    drv(1, 96'h14, 16'h1, 0, 1, 0, 0, 0, 5'd0);
    nx();
    chk1("ds_fl_v", bus.o_valid, 1'b1);
    chk1("ds_fl", bus.o_in_delay_slot, 1'b0);
    idle(1);
    nx();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 3) != 0,
          {$urandom, $urandom, $urandom},
          16'($urandom), 1'($urandom),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0, 1'($urandom),
          5'($urandom));
      nx();
    end

    // async reset in the middle of a stall
    drv(1, 96'h77, 16'h7, 1, 0, 0, 0, 0, 5'd3);
    nx();
    drv(1, 96'h88, 16'h8, 0, 0, 0, 0, 0, 5'd3);
    nx();
    chk1("mr_skid", bus.o_ready, 1'b0);
    idle(0);
    #2 resetn = 1'b0;
    #1 reset_vals("mr");
    nx();
    #2 resetn = 1'b1;
    drv(1, 96'h99, 16'h9, 0, 1, 0, 0, 0, 5'd0);
    nx();
    chkw("mr_after", 128'(bus.o_data), 128'(96'h99));
    idle(1);
    nx();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
